// File: rtl/inv_mask_pkg.sv
// Shared definitions for the inverse-mask encoder.
//   W      mask width (must equal 2**SW)
//   SW     shift-amount width
//   CNT_W  malformed-mask counter width
//   mask_of(k)       forward map of the barrel-shifter decoder: shift k -> inverse mask
//   is_valid_mask(m) true when m is a mask the decoder can produce
package inv_mask_pkg;

    localparam int W     = 8;
    localparam int SW    = 3;
    localparam int CNT_W = 8;

    // k=0 has no bits set; k=1..W-1 keeps the low W-k bits.
    function automatic logic [W-1:0] mask_of(input int k);
        logic [W-1:0] m;
        if (k <= 0 || k >= W) begin
            m = '0;
        end else begin
            m = W'((1 << (W - k)) - 1);
        end
        return m;
    endfunction

    // A legal mask is a run of ones anchored at bit 0 that never reaches the MSB.
    function automatic logic is_valid_mask(input logic [W-1:0] m);
        logic [W-1:0] nxt;
        nxt = m + W'(1);
        return !m[W-1] && ((m & nxt) == '0);
    endfunction

endpackage

// File: rtl/inv_mask_chk.sv
// Combinational mask checker/encoder sitting between the capture and encode stages.
//   mask  in   W   captured inverse mask
//   amt   out  SW  recovered shift amount (0 when malformed)
//   err   out  1   mask is malformed
module inv_mask_chk #(
    parameter int W  = inv_mask_pkg::W,
    parameter int SW = inv_mask_pkg::SW
) (
    input  logic [W-1:0]  mask,
    output logic [SW-1:0] amt,
    output logic          err
);

    logic [W-1:0] mask_inc;
    logic         well_formed;
    logic [SW:0]  pop;
    logic [SW:0]  diff;

    // A run of low ones plus one carries into a single bit with no overlap.
    assign mask_inc    = mask + W'(1);
    assign well_formed = !mask[W-1] && ((mask & mask_inc) == '0);

    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + {{SW{1'b0}}, mask[i]};
        end
    end

    // Done in SW+1 bits so W itself is representable before truncation.
    assign diff = (SW+1)'(W) - pop;

    always_comb begin
        amt = '0;
        err = 1'b1;
        if (well_formed) begin
            err = 1'b0;
            amt = (mask == '0) ? '0 : diff[SW-1:0];
        end
    end

endmodule

// File: rtl/inv_mask_encoder.sv
// Inverse-mask encoder: recovers the shift amount from a barrel-shifter inverse mask
// through a two-stage valid/ready pipeline, flagging and counting malformed masks.
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_mask is valid
//   in_ready   out  1      encoder accepts this cycle
//   in_mask    in   W      inverse mask
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_amt    out  SW     recovered shift amount
//   out_err    out  1      mask was malformed
//   err_clr    in   1      synchronous clear of err_cnt (wins over increment)
//   err_cnt    out  CNT_W  saturating count of delivered malformed results
//
// Per-stage state (the valid bit plus the downstream ready):
//   state           | meaning
//   empty           | v=0, stage loads whatever is offered
//   full-held       | v=1, downstream stalled, contents frozen
//   full-advancing  | v=1, contents move on and the stage reloads the same edge
module inv_mask_encoder #(
    parameter int W     = inv_mask_pkg::W,
    parameter int SW    = inv_mask_pkg::SW,
    parameter int CNT_W = inv_mask_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_amt,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    import inv_mask_pkg::mask_of;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic          v1;
    logic          v2;
    logic          ready1;
    logic          ready2;
    logic [W-1:0]  mask1;
    logic [SW-1:0] chk_amt;
    logic          chk_err;
    logic [SW-1:0] amt2;
    logic          err2;
    logic          err_fire;

    // Readies look only downstream, so in_ready never depends on in_valid.
    assign ready2   = !v2 || out_ready;
    assign ready1   = !v1 || ready2;
    assign in_ready = ready1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            mask1 <= '0;
        end else if (ready1) begin
            v1 <= in_valid;
            if (in_valid) begin
                mask1 <= in_mask;
            end
        end
    end

    inv_mask_chk #(
        .W  (W),
        .SW (SW)
    ) u_chk (
        .mask (mask1),
        .amt  (chk_amt),
        .err  (chk_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            amt2 <= '0;
            err2 <= 1'b0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1) begin
                amt2 <= chk_amt;
                err2 <= chk_err;
            end
        end
    end

    assign out_valid = v2;
    assign out_amt   = amt2;
    assign out_err   = err2;

    assign err_fire = v2 && out_ready && err2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err_fire && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    // A well-formed result must map back to the captured mask through the decoder.
    a_roundtrip: assert property (@(posedge clk) disable iff (!rst_n)
        (v1 && !chk_err) |-> (mask_of(int'(chk_amt)) == mask1));

endmodule

// File: tb/tb_inv_mask_encoder.sv
module tb_inv_mask_encoder;
    import inv_mask_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [W-1:0]    in_mask = '0;
    logic            out_ready = 1'b0;
    logic            err_clr = 1'b0;
    logic            in_ready, out_valid, out_err;
    logic [SW-1:0]   out_amt;
    logic [CNT_W-1:0] err_cnt;
    logic            in_ready2, out_valid2, out_err2;
    logic [SW-1:0]   out_amt2;
    logic [1:0]      err_cnt2;

    inv_mask_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
        .out_amt(out_amt), .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    inv_mask_encoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_mask(in_mask), .out_valid(out_valid2), .out_ready(out_ready),
        .out_amt(out_amt2), .out_err(out_err2), .err_clr(err_clr), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] mask; logic [2:0] amt; logic err; } vec_t;
    typedef struct { logic [2:0] amt; logic err; int cyc; } exp_t;

    vec_t       tbl [12];
    logic [7:0] feed_q [$];
    exp_t       tq [$];
    exp_t       sb [$];

    int checks = 0, passes = 0;
    int cyc = 0, accepts = 0, first_acc = -1, last_out = -1;
    int exp_cnt = 0, exp_cnt2 = 0;
    bit last_in_fire = 1'b1, held_valid = 1'b0, held_err = 1'b0;
    logic [2:0] held_amt = '0;
    bit vld_rand = 1'b0, rdy_rand = 1'b0, rdy_force = 1'b1, chk_lat = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: the shift amount is whichever k the decoder maps onto this mask.
    function automatic exp_t ref_encode(input logic [7:0] m);
        exp_t e;
        e.amt = '0;
        e.err = !is_valid_mask(m);
        e.cyc = 0;
        for (int k = 0; k < 8; k++) begin
            if (!e.err && mask_of(k) == m) e.amt = 3'(k);
        end
        return e;
    endfunction

    // One clock: drive at the falling edge, sample 1ns later, score handshakes.
    task automatic step();
        bit in_fire, out_fire, pop_err;
        exp_t e;
        if (!in_valid || last_in_fire) begin
            in_valid = (feed_q.size() > 0) && (!vld_rand || $urandom_range(0, 3) != 0);
            in_mask  = in_valid ? feed_q[0] : W'($urandom);
        end
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        #1;
        check("err_cnt", int'(err_cnt), exp_cnt);
        check("err_cnt_w2", int'(err_cnt2), exp_cnt2);
        if (held_valid) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_amt", int'(out_amt), int'(held_amt));
            check("hold_err", int'(out_err), int'(held_err));
        end
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        pop_err  = 1'b0;
        if (out_fire) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_amt", int'(out_amt), int'(e.amt));
                check("out_err", int'(out_err), int'(e.err));
                if (chk_lat) check("latency", cyc - e.cyc, 2);
                pop_err  = e.err;
                last_out = cyc;
            end
        end
        if (err_clr) begin
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else if (pop_err) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        if (in_fire) begin
            e = (tq.size() > 0) ? tq.pop_front() : ref_encode(in_mask);
            e.cyc = cyc;
            sb.push_back(e);
            void'(feed_q.pop_front());
            accepts++;
            if (first_acc < 0) first_acc = cyc;
        end
        last_in_fire = in_fire;
        held_valid   = out_valid && !out_ready;
        held_amt     = out_amt;
        held_err     = out_err;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((feed_q.size() > 0 || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("drain_timeout", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0]  = '{8'h00, 3'd0, 1'b0};
        tbl[1]  = '{8'h7F, 3'd1, 1'b0};
        tbl[2]  = '{8'h3F, 3'd2, 1'b0};
        tbl[3]  = '{8'h1F, 3'd3, 1'b0};
        tbl[4]  = '{8'h0F, 3'd4, 1'b0};
        tbl[5]  = '{8'h07, 3'd5, 1'b0};
        tbl[6]  = '{8'h03, 3'd6, 1'b0};
        tbl[7]  = '{8'h01, 3'd7, 1'b0};
        tbl[8]  = '{8'hFF, 3'd0, 1'b1};
        tbl[9]  = '{8'h05, 3'd0, 1'b1};
        tbl[10] = '{8'h80, 3'd0, 1'b1};
        tbl[11] = '{8'hFE, 3'd0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_amt", int'(out_amt), 0);
        check("rst_out_err", int'(out_err), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // 1: well-formed sweep, back-to-back, latency 2, one per cycle
        first_acc = -1;
        chk_lat   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            feed_q.push_back(tbl[i].mask);
            tq.push_back('{tbl[i].amt, tbl[i].err, 0});
        end
        drain(50);
        chk_lat = 1'b0;
        check("sweep_span", last_out - first_acc, 9);
        check("sweep_err_cnt", int'(err_cnt), 0);

        // 2: malformed masks
        for (int i = 8; i < 12; i++) begin
            feed_q.push_back(tbl[i].mask);
            tq.push_back('{tbl[i].amt, tbl[i].err, 0});
        end
        drain(50);
        check("malformed_err_cnt", int'(err_cnt), 4);

        // 3: five-cycle stall with continuous input
        accepts   = 0;
        rdy_force = 1'b0;
        for (int k = 0; k < 8; k++) feed_q.push_back(mask_of(7 - k));
        repeat (5) step();
        check("stall_accepts", accepts, 2);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_out_valid", int'(out_valid), 1);
        rdy_force = 1'b1;
        drain(60);
        check("stall_total", accepts, 8);

        // 4: saturation of the 2-bit counter and clear-vs-increment priority
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        feed_q = '{8'hFF, 8'h05, 8'h80, 8'hFE, 8'hC3};
        drain(50);
        check("sat_err_cnt8", int'(err_cnt), 5);
        check("sat_err_cnt2", int'(err_cnt2), 3);
        rdy_force = 1'b0;
        feed_q.push_back(8'hFF);
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check("clr_setup_valid", int'(out_valid), 1);
        rdy_force = 1'b1;
        err_clr   = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        check("clr_wins_cnt8", int'(err_cnt), 0);
        check("clr_wins_cnt2", int'(err_cnt2), 0);

        // 5: reset with both stages full
        feed_q = '{8'hFF, 8'h05};
        drain(30);
        rdy_force = 1'b0;
        feed_q = '{8'h3F, 8'h1F, 8'h0F};
        repeat (4) step();
        check("full_out_valid", int'(out_valid), 1);
        check("full_in_ready", int'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", int'(out_valid), 0);
        check("async_err_cnt", int'(err_cnt), 0);
        check("async_in_ready", int'(in_ready), 1);
        sb.delete();
        feed_q.delete();
        tq.delete();
        exp_cnt      = 0;
        exp_cnt2     = 0;
        held_valid   = 1'b0;
        last_in_fire = 1'b1;
        in_valid     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        rdy_force = 1'b1;
        repeat (5) step();
        check("post_rst_out_valid", int'(out_valid), 0);
        feed_q.push_back(8'h3F);
        drain(20);

        // 6: random masks with random valid/ready
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) != 0) feed_q.push_back(mask_of(int'($urandom_range(0, 7))));
            else feed_q.push_back(8'($urandom));
        end
        vld_rand = 1'b1;
        rdy_rand = 1'b1;
        drain(20000);
        vld_rand = 1'b0;
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
